// File: rtl/decode_redirect_if.sv
// decode_redirect_if: fetch redirect bus; decode drives the request and targets, fetch/EX drive the stalls.
interface decode_redirect_if;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcindex;
  logic        ex_if_stall;
  logic        iss_stall;
  modport master (
    output id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_rega, id_if_pcindex,
    input  ex_if_stall, iss_stall
  );
  modport slave (
    input  id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_rega, id_if_pcindex,
    output ex_if_stall, iss_stall
  );
endinterface

// File: rtl/decode_redirect.sv
// decode_redirect: resolves J/JR/BEQ/BNE in ID, holds a registered redirect until fetch takes it, then squashes the wrong path.
// DECODE_REDIRECT_EXC_EN: when defined, SYSCALL redirects to the exception vector (selpctype 11).
module decode_redirect #(
  parameter int unsigned SQUASH_N   = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic              clock,
  input  logic              reset,
  decode_redirect_if.master rd,
  input  logic [31:0]       if_id_instruc,
  input  logic [31:0]       if_id_nextpc,
  input  logic              ex_wr_en,
  input  logic [4:0]        ex_wr_addr,
  input  logic [31:0]       rf_rega,
  input  logic [31:0]       rf_regb,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic              id_stall,
  output logic [31:0]       id_ex_instruc,
  output logic [31:0]       id_ex_nextpc
);
  localparam int CW = $clog2(SQUASH_N + 2);
  typedef enum logic [1:0] {RUN, WAIT_OP, REDIRECT, SQUASH} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    type_q, type_d, type_w;
  logic [31:0]   imd_q, imd_d, rega_q, rega_d, index_q, index_d;
  logic [31:0]   instr_q, instr_d, nextpc_q, nextpc_d;
  logic [5:0]    op, funct;
  logic          is_j, is_jr, is_beq, is_bne, is_br, is_sys, taken, hazard, decode_st, decode;
  // fetch hardwires the vector, so it only needs to be a legal word address
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_vec_check
    $error("EXC_VECTOR must be word aligned");
  end
  assign op     = if_id_instruc[31:26];
  assign funct  = if_id_instruc[5:0];
  assign id_rs  = if_id_instruc[25:21];
  assign id_rt  = if_id_instruc[20:16];
  assign is_j   = op == 6'b000010;
  assign is_beq = op == 6'b000100;
  assign is_bne = op == 6'b000101;
  assign is_br  = is_beq || is_bne;
  assign is_jr  = op == 6'b000000 && funct == 6'b001000;
`ifdef DECODE_REDIRECT_EXC_EN
  assign is_sys = op == 6'b000000 && funct == 6'b001100;
`else
  assign is_sys = 1'b0;
`endif
  assign taken  = is_j || is_jr || is_sys || (is_beq && rf_rega == rf_regb) || (is_bne && rf_rega != rf_regb);
  assign type_w = is_j ? 2'b10 : is_jr ? 2'b01 : is_sys ? 2'b11 : 2'b00;
  // rt is only a source for the compare branches
  assign hazard = ex_wr_en && ex_wr_addr != 5'd0 &&
                  (((is_jr || is_br) && ex_wr_addr == id_rs) || (is_br && ex_wr_addr == id_rt));
  assign decode_st = state_q == RUN || state_q == WAIT_OP;
  assign decode    = decode_st && !rd.ex_if_stall;
  assign id_stall  = !reset && decode_st && hazard;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    imd_d    = imd_q;
    rega_d   = rega_q;
    index_d  = index_q;
    instr_d  = rd.ex_if_stall ? instr_q : 32'h0;
    nextpc_d = rd.ex_if_stall ? nextpc_q : if_id_nextpc;
    if (decode) begin
      state_d = hazard ? WAIT_OP : taken ? REDIRECT : RUN;
      instr_d = hazard ? 32'h0 : if_id_instruc;
      if (!hazard && taken) begin
        type_d  = type_w;
        imd_d   = if_id_nextpc + {{14{if_id_instruc[15]}}, if_id_instruc[15:0], 2'b00};
        rega_d  = rf_rega;
        index_d = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
      end
    end else if (state_q == REDIRECT && !(rd.ex_if_stall || rd.iss_stall)) begin
      state_d = SQUASH_N == 0 ? RUN : SQUASH;
      cnt_d   = CW'(SQUASH_N);
    end else if (state_q == SQUASH && !rd.ex_if_stall) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_d == '0 ? RUN : SQUASH;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      type_q   <= 2'b00;
      imd_q    <= '0;
      rega_q   <= '0;
      index_q  <= '0;
      instr_q  <= '0;
      nextpc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      imd_q    <= imd_d;
      rega_q   <= rega_d;
      index_q  <= index_d;
      instr_q  <= instr_d;
      nextpc_q <= nextpc_d;
    end
  end
  assign rd.id_if_selpcsource = state_q == REDIRECT;
  assign rd.id_if_selpctype   = type_q;
  assign rd.id_if_pcimd2ext   = imd_q;
  assign rd.id_if_rega        = rega_q;
  assign rd.id_if_pcindex     = index_q;
  assign id_ex_instruc        = instr_q;
  assign id_ex_nextpc         = nextpc_q;
endmodule
